// File: rtl/find_better_neighbors.sv
// -----------------------------------------------------------------------------
// find_better_neighbors
//
// Routing-table stage that runs after the sink-list fixer. It reads
// neighborCount from the shared 16-bit node memory and scans qValue[] once to
// find the largest value. It then scans again and copies the neighborID of
// every neighbour whose qValue qualifies into betterneighbors[]. Finally it
// writes the number of copied entries to betterneighborCount.
//
// Memory map (byte addresses, words at even addresses):
//   0x048 + 2i  neighborID[i]
//   0x1C8 + 2i  qValue[i]
//   0x668 + 2k  betterneighbors[k]
//   0x68A       neighborCount
//   0x68C       betterneighborCount
//
// The memory has a synchronous read: the data for the address driven in one
// cycle appears on mem_data_out in the next cycle.
//
// Ports:
//   clock                     in   system clock, rising edge
//   nrst                      in   asynchronous active-low reset
//   en                        in   start request (one or more cycles)
//   done_fixSinkList          in   upstream stage complete
//   address[10:0]             out  byte address to shared memory
//   wr_en                     out  memory write strobe
//   mem_data_out[15:0]        in   memory read data
//   mem_data_in[15:0]         out  memory write data (0 when not writing)
//   done_findBetterNeighbors  out  scan complete, held until restart/reset
//
// Optional feature (macro FBN_QMARGIN_EN):
//   When FBN_QMARGIN_EN is defined, a neighbour qualifies if
//   q + QMARGIN >= maxQ. When it is undefined, a neighbour qualifies only if
//   q == maxQ.
// -----------------------------------------------------------------------------
module find_better_neighbors #(
  parameter int          MAX_NEIGHBORS = 64,
  parameter int          MAX_BETTER    = 16,
  parameter logic [15:0] QMARGIN       = 16'd0
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic        done_fixSinkList,
  output logic [10:0] address,
  output logic        wr_en,
  input  logic [15:0] mem_data_out,
  output logic [15:0] mem_data_in,
  output logic        done_findBetterNeighbors
);

  // One extra bit so the index can hold MAX_NEIGHBORS without wrapping.
  localparam int IDX_W = $clog2(MAX_NEIGHBORS + 1);
  localparam int K_W   = $clog2(MAX_BETTER + 1);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [K_W-1:0]   K_ONE   = K_W'(1);
  localparam logic [K_W-1:0]   K_CAP   = K_W'(MAX_BETTER);

  localparam logic [10:0] ADDR_NCNT = 11'h68A;
  localparam logic [10:0] ADDR_BCNT = 11'h68C;
  localparam logic [10:0] QV_BASE   = 11'h1C8;
  localparam logic [10:0] ID_BASE   = 11'h048;
  localparam logic [10:0] BN_BASE   = 11'h668;

`ifdef FBN_QMARGIN_EN
  localparam logic [16:0] MARGIN17 = {1'b0, QMARGIN};
`else
  localparam logic [16:0] MARGIN17 = {1'b0, QMARGIN} & 17'd0;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_CNT,
    S_LAT_CNT,
    S_MAX_RD,
    S_MAX_CMP,
    S_SEL_RD,
    S_SEL_CMP,
    S_RD_ID,
    S_WR_BETTER,
    S_WR_COUNT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_n;
  logic [K_W-1:0]    r_k;
  logic [15:0]       r_maxq;
  logic              r_pend;

  logic [IDX_W-1:0]  w_idx_inc;
  logic [IDX_W-1:0]  w_n_clamped;
  logic              w_last;
  logic              w_cap;
  logic              w_take;
  logic              w_start;

  // Both cases use 17-bit arithmetic so q + margin cannot overflow. When the
  // feature is disabled the margin is zero, and the test is exact equality.
  function automatic logic f_qualifies(input logic [15:0] q,
                                       input logic [15:0] maxq);
`ifdef FBN_QMARGIN_EN
    return (({1'b0, q} + MARGIN17) >= {1'b0, maxq});
`else
    return (({1'b0, q} + MARGIN17) == {1'b0, maxq});
`endif
  endfunction

  assign w_idx_inc   = r_idx + IDX_ONE;
  assign w_last      = (w_idx_inc == r_n);
  assign w_cap       = (r_k == K_CAP);
  assign w_take      = f_qualifies(mem_data_out, r_maxq) && !w_cap;
  assign w_n_clamped = (mem_data_out > 16'(MAX_NEIGHBORS)) ? IDX_W'(MAX_NEIGHBORS)
                                                           : mem_data_out[IDX_W-1:0];
  // A request made before the upstream stage finishes is held in r_pend.
  assign w_start     = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                       done_fixSinkList && (en || r_pend);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next                   = r_state;
    address                  = 11'd0;
    wr_en                    = 1'b0;
    mem_data_in              = 16'd0;
    done_findBetterNeighbors = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_RD_CNT;
      end
      S_RD_CNT: begin
        address = ADDR_NCNT;
        w_next  = S_LAT_CNT;
      end
      S_LAT_CNT: begin
        w_next = (mem_data_out == 16'd0) ? S_WR_COUNT : S_MAX_RD;
      end
      S_MAX_RD: begin
        address = QV_BASE + 11'({r_idx, 1'b0});
        w_next  = S_MAX_CMP;
      end
      S_MAX_CMP: begin
        w_next = w_last ? S_SEL_RD : S_MAX_RD;
      end
      S_SEL_RD: begin
        address = QV_BASE + 11'({r_idx, 1'b0});
        w_next  = S_SEL_CMP;
      end
      S_SEL_CMP: begin
        if (w_take)      w_next = S_RD_ID;
        else if (w_last) w_next = S_WR_COUNT;
        else             w_next = S_SEL_RD;
      end
      S_RD_ID: begin
        address = ID_BASE + 11'({r_idx, 1'b0});
        w_next  = S_WR_BETTER;
      end
      S_WR_BETTER: begin
        // The neighborID read in S_RD_ID is on the bus now.
        address     = BN_BASE + 11'({r_k, 1'b0});
        wr_en       = 1'b1;
        mem_data_in = mem_data_out;
        w_next      = w_last ? S_WR_COUNT : S_SEL_RD;
      end
      S_WR_COUNT: begin
        address     = ADDR_BCNT;
        wr_en       = 1'b1;
        mem_data_in = 16'(r_k);
        w_next      = S_DONE;
      end
      S_DONE: begin
        done_findBetterNeighbors = 1'b1;
        if (w_start) w_next = S_RD_CNT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_idx  <= '0;
      r_n    <= '0;
      r_k    <= '0;
      r_maxq <= '0;
      r_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_pend <= 1'b0;
            r_idx  <= '0;
            r_k    <= '0;
            r_maxq <= '0;
          end else if (en) begin
            r_pend <= 1'b1;
          end
        end
        S_LAT_CNT: r_n <= w_n_clamped;
        S_MAX_CMP: begin
          if (mem_data_out > r_maxq) r_maxq <= mem_data_out;
          r_idx <= w_last ? '0 : w_idx_inc;
        end
        S_SEL_CMP: begin
          if (!w_take) r_idx <= w_idx_inc;
        end
        S_WR_BETTER: begin
          r_k   <= r_k + K_ONE;
          r_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_find_better_neighbors.sv
// -----------------------------------------------------------------------------
// Directed testbench for find_better_neighbors. It models the shared memory
// with a synchronous read and logs every write the DUT makes.
// -----------------------------------------------------------------------------
`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_find_better_neighbors;

  logic        clock;
  logic        nrst;
  logic        en;
  logic        done_fixSinkList;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;
  logic        done_findBetterNeighbors;

  int checks = 0;
  int errors = 0;

  // memory model plus write log
  logic [15:0] mem [0:1023];
  logic        tb_we;
  logic        tb_clr;
  logic [10:0] tb_wa;
  logic [15:0] tb_wd;
  int          wr_total  = 0;
  int          wr_better = 0;
  int          wr_bad    = 0;
  logic [10:0] last_addr = 11'd0;
  logic [15:0] last_data = 16'd0;

  find_better_neighbors #(
    .MAX_NEIGHBORS(64),
    .MAX_BETTER   (16),
    .QMARGIN      (16'd2)
  ) dut (
    .clock                   (clock),
    .nrst                    (nrst),
    .en                      (en),
    .done_fixSinkList        (done_fixSinkList),
    .address                 (address),
    .wr_en                   (wr_en),
    .mem_data_out            (mem_data_out),
    .mem_data_in             (mem_data_in),
    .done_findBetterNeighbors(done_findBetterNeighbors)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    mem_data_out <= mem[address[10:1]];
    if (tb_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
    end else if (wr_en) begin
      mem[address[10:1]] <= mem_data_in;
      wr_total  <= wr_total + 1;
      last_addr <= address;
      last_data <= mem_data_in;
      if (address >= 11'h668 && address <= 11'h686) wr_better <= wr_better + 1;
      if (address >= 11'h688 && address != 11'h68C) wr_bad <= wr_bad + 1;
    end else if (tb_we) begin
      mem[tb_wa[10:1]] <= tb_wd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rd(input logic [10:0] a);
    return mem[a[10:1]];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [10:0] a, input logic [15:0] d);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic clear_mem();
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
  endtask

  task automatic load_table(input int n, input logic [15:0] q [4], input logic [15:0] id [4]);
    clear_mem();
    load(11'h68A, 16'(n));
    for (int i = 0; i < 4; i++) begin
      load(11'(32'h1C8 + 2 * i), q[i]);
      load(11'(32'h048 + 2 * i), id[i]);
    end
  endtask

  // Pulses en and returns the cycle (1 = first cycle after start) when done is high.
  task automatic run_scan(input int limit, output int n);
    en = 1'b1;
    tick();
    en = 1'b0;
    n = 1;
    while (done_findBetterNeighbors !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int w0, wb0, wx0;
    logic [15:0] qv [4];
    logic [15:0] idv [4];

    nrst = 1'b0;
    en = 1'b0;
    done_fixSinkList = 1'b1;
    tb_we = 1'b0;
    tb_clr = 1'b0;
    tb_wa = 11'd0;
    tb_wd = 16'd0;
    #2;
    `CHK("rst_addr", address, 11'd0)
    `CHK("rst_wren", wr_en, 1'b0)
    `CHK("rst_wdata", mem_data_in, 16'd0)
    `CHK("rst_done", done_findBetterNeighbors, 1'b0)
    tick();
    tick();
    nrst = 1'b1;

    // basic select
    qv = '{16'd5, 16'd9, 16'd9, 16'd3};
    idv = '{16'h11, 16'h22, 16'h33, 16'h44};
    load_table(4, qv, idv);
    load(11'h66C, 16'hBEEF);
    w0 = wr_total;
    run_scan(200, n);
    `CHK("basic_latency", n, 24)
    `CHK("basic_b0", rd(11'h668), 16'h22)
    `CHK("basic_b1", rd(11'h66A), 16'h33)
    `CHK("basic_cnt", rd(11'h68C), 16'd2)
    `CHK("basic_untouched", rd(11'h66C), 16'hBEEF)
    `CHK("basic_nwr", wr_total - w0, 3)
    tick();
    tick();
    tick();
    `CHK("basic_done_held", done_findBetterNeighbors, 1'b1)

    // empty table
    load(11'h68A, 16'd0);
    w0 = wr_total;
    run_scan(200, n);
    `CHK("empty_latency", n, 4)
    `CHK("empty_nwr", wr_total - w0, 1)
    `CHK("empty_addr", last_addr, 11'h68C)
    `CHK("empty_data", last_data, 16'd0)
    `CHK("empty_cnt", rd(11'h68C), 16'd0)

    // cap at 16 better neighbours
    clear_mem();
    load(11'h68A, 16'd20);
    for (int i = 0; i < 20; i++) begin
      load(11'(32'h1C8 + 2 * i), 16'd7);
      load(11'(32'h048 + 2 * i), 16'(32'h100 + i));
    end
    wb0 = wr_better;
    wx0 = wr_bad;
    run_scan(1000, n);
    `CHK("cap_latency", n, 116)
    `CHK("cap_nbetter", wr_better - wb0, 16)
    `CHK("cap_nbad", wr_bad - wx0, 0)
    `CHK("cap_cnt", rd(11'h68C), 16'd16)
    `CHK("cap_b0", rd(11'h668), 16'h100)
    `CHK("cap_b15", rd(11'h686), 16'h10F)

    // count above 64 is clamped; last entry i=63 is reached
    clear_mem();
    load(11'h68A, 16'd100);
    load(11'(32'h1C8 + 2 * 63), 16'd50);
    load(11'(32'h048 + 2 * 63), 16'h63);
    load(11'h248, 16'd100);
    load(11'h0C8, 16'h64);
    run_scan(1000, n);
    `CHK("clamp_latency", n, 262)
    `CHK("clamp_cnt", rd(11'h68C), 16'd1)
    `CHK("clamp_b0", rd(11'h668), 16'h63)

    // handshake: request waits for done_fixSinkList, en while busy ignored
    qv = '{16'd5, 16'd9, 16'd9, 16'd3};
    idv = '{16'h11, 16'h22, 16'h33, 16'h44};
    load_table(4, qv, idv);
    done_fixSinkList = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    `CHK("hs_done_held", done_findBetterNeighbors, 1'b1)
    repeat (9) tick();
    `CHK("hs_wait_addr", address, 11'd0)
    done_fixSinkList = 1'b1;
    tick();
    n = 1;
    `CHK("hs_start_addr", address, 11'h68A)
    `CHK("hs_done_clr", done_findBetterNeighbors, 1'b0)
    repeat (4) begin
      tick();
      n++;
    end
    en = 1'b1;
    tick();
    n++;
    en = 1'b0;
    while (done_findBetterNeighbors !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    `CHK("hs_latency", n, 24)
    `CHK("hs_cnt", rd(11'h68C), 16'd2)

    // reset during the selection pass (cycle 16 = first ID write)
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (15) tick();
    `CHK("mid_wren", wr_en, 1'b1)
    `CHK("mid_addr", address, 11'h668)
    `CHK("mid_wdata", mem_data_in, 16'h22)
    nrst = 1'b0;
    #1;
    `CHK("abort_addr", address, 11'd0)
    `CHK("abort_wren", wr_en, 1'b0)
    `CHK("abort_wdata", mem_data_in, 16'd0)
    `CHK("abort_done", done_findBetterNeighbors, 1'b0)
    tick();
    nrst = 1'b1;
    qv = '{16'd0, 16'd0, 16'd0, 16'd0};
    idv = '{16'hA1, 16'hA2, 16'hA3, 16'hA4};
    load_table(3, qv, idv);
    load(11'h66E, 16'hBEEF);
    run_scan(200, n);
    `CHK("post_latency", n, 22)
    `CHK("post_cnt", rd(11'h68C), 16'd3)
    `CHK("post_b0", rd(11'h668), 16'hA1)
    `CHK("post_b2", rd(11'h66C), 16'hA3)
    `CHK("post_untouched", rd(11'h66E), 16'hBEEF)

    // margin
    qv = '{16'd5, 16'd9, 16'd8, 16'd6};
    idv = '{16'h11, 16'h22, 16'h33, 16'h44};
    load_table(4, qv, idv);
    run_scan(200, n);
    `CHK("margin_b0", rd(11'h668), 16'h22)
`ifdef FBN_QMARGIN_EN
    `CHK("margin_latency", n, 24)
    `CHK("margin_cnt", rd(11'h68C), 16'd2)
    `CHK("margin_b1", rd(11'h66A), 16'h33)
`else
    `CHK("margin_latency", n, 22)
    `CHK("margin_cnt", rd(11'h68C), 16'd1)
    `CHK("margin_b1", rd(11'h66A), 16'h0)
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/find_better_neighbors.md
Name: find_better_neighbors

Overview:
- Routing-table stage directly downstream of the sink-list fixer. It runs after done_fixSinkList is asserted.
- It scans the neighbour table in the shared 16-bit node memory and finds the maximum qValue.
- Every neighbour whose qValue equals that maximum is written into the betterneighbors list, and betterneighborCount is updated.
- The next-hop selection logic consumes its done flag.

Parameters:
- MAX_NEIGHBORS, 64: capacity of the neighborID and qValue arrays.
- MAX_BETTER, 16: capacity of the betterneighbors array.
- QMARGIN, 16'd0: tolerance below the maximum qValue. Used only with the optional feature.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- nrst, input, 1: asynchronous active-low reset.
- en, input, 1: start request, pulse of one or more cycles.
- done_fixSinkList, input, 1: upstream stage complete.
- address, output, 11: byte address to the shared memory. Words sit at even addresses.
- wr_en, output, 1: memory write strobe.
- mem_data_out, input, 16: memory read data.
- mem_data_in, output, 16: memory write data.
- done_findBetterNeighbors, output, 1: scan complete, held high.

Behaviour:
- Memory model: synchronous read. Data for the address presented in cycle N is valid on mem_data_out in cycle N+1. A write commits at the edge where wr_en=1.
- Address map:
  - neighborCount at 0x68A.
  - qValue[i] at 0x1C8+2i.
  - neighborID[i] at 0x48+2i.
  - betterneighbors[k] at 0x668+2k.
  - betterneighborCount at 0x68C.
- Reset (nrst=0, async):
  - State goes to IDLE.
  - address=0, wr_en=0, mem_data_in=0, done_findBetterNeighbors=0.
  - Internal counters, maximum and pending flag are cleared.
- Start:
  - In IDLE, en=1 with done_fixSinkList=1 moves to RD_CNT on the next edge.
  - en=1 with done_fixSinkList=0 sets a pending flag. The block starts the first cycle done_fixSinkList=1.
  - en while busy is ignored.
  - A start from DONE clears done_findBetterNeighbors and reruns the scan.
- States:
  - IDLE.
  - RD_CNT: drive 0x68A.
  - LAT_CNT: latch N = min(mem_data_out, MAX_NEIGHBORS). If N=0, go to WR_COUNT with count 0.
  - SCAN_MAX: drive qValue[i]; the next cycle compares. maxQ starts at 0 and is replaced when q > maxQ (unsigned). Loops i=0..N-1.
  - SCAN_SEL: re-read qValue[i]. If it qualifies, read neighborID[i] in RD_ID. Then WR_BETTER writes the ID to betterneighbors[k] with wr_en=1 for exactly one cycle, and k increments.
  - WR_COUNT: write k to 0x68C, wr_en=1 for one cycle.
  - DONE: done_findBetterNeighbors=1. The block stays here until a new start or reset.
- Qualification: q == maxQ.
- Boundaries:
  - Once k reaches MAX_BETTER, remaining qualifiers are skipped without writes. Count saturates at 16.
  - All-zero qValues: every neighbour qualifies, subject to the cap.
  - Counts above 64 are clamped to 64.
  - The index register is 7 bits wide, so it does not wrap at i=63.
- Output rules:
  - wr_en is asserted only in WR_BETTER and WR_COUNT.
  - mem_data_in is held at 0 outside writes.
  - betterneighbors entries beyond k are left untouched.
- Latency for N neighbours with B writes: 2 (count) + 2N (max) + 2N (select) + 2B (ID read and write) + 1 (count write) cycles, then DONE.
- Reset mid-scan aborts immediately. Memory keeps any partial writes.

Optional Feature:
- Macro: FBN_QMARGIN_EN.
- When defined, qualification becomes q + QMARGIN >= maxQ, computed in 17 bits to avoid overflow.
- When undefined, qualification is exact equality and QMARGIN is unused.

Test Plan:
- Basic select: neighborCount=4, qValue={5,9,9,3}, IDs={0x11,0x22,0x33,0x44}.
  - betterneighbors[0..1]={0x22,0x33}, betterneighborCount=2.
  - done rises 24 cycles after start and stays high.
- Empty: neighborCount=0.
  - Only the 0x68C write occurs, data 0.
  - done at start+4.
  - No other wr_en pulses.
- Cap: neighborCount=20, all qValue=7.
  - Exactly 16 ID writes to 0x668..0x686.
  - Count written = 16. No writes at 0x688 or above.
- Handshake: en pulsed while done_fixSinkList=0, and done_fixSinkList rises 10 cycles later.
  - The scan starts the cycle after the rise.
  - An en pulse mid-scan has no effect.
- Reset: nrst dropped during SCAN_SEL.
  - Outputs are 0 within the same cycle, with no clock edge needed.
  - After release, a fresh en produces a complete correct scan.
- Margin (FBN_QMARGIN_EN, QMARGIN=2): qValue={5,9,8,6}.
  - Selects neighbours 1 and 2, count=2.
  - Without the macro, only neighbour 1 is selected.
